// File: rtl/nand_pkg.sv
// Shared encodings for the NAND command sequencer: op codes, opcode bytes,
// pin vectors {CE_n, CLE, ALE, WE_n, RE_n}, FSM states and the per-op phase tables.
package nand_pkg;

    typedef enum logic [1:0] {
        OP_RESET     = 2'b00,
        OP_READ_ID   = 2'b01,
        OP_PAGE_READ = 2'b10,
        OP_RSVD      = 2'b11
    } nand_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RELEASE,
        ST_RBWAIT,
        ST_CMPL
    } state_e;

    typedef enum logic [1:0] {
        PH_CMD,
        PH_ADDR,
        PH_RBWAIT,
        PH_DATA
    } phase_kind_e;

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_READ_ID = 8'h90;
    localparam logic [7:0] CMD_READ1   = 8'h00;
    localparam logic [7:0] CMD_READ2   = 8'h30;

    localparam logic [4:0] VEC_CMD_SETUP  = 5'b01001;
    localparam logic [4:0] VEC_CMD_HOLD   = 5'b01011;
    localparam logic [4:0] VEC_ADDR_SETUP = 5'b00101;
    localparam logic [4:0] VEC_ADDR_HOLD  = 5'b00111;
    localparam logic [4:0] VEC_DATA_SETUP = 5'b00010;
    localparam logic [4:0] VEC_DATA_HOLD  = 5'b00011;
    localparam logic [4:0] VEC_IDLE       = 5'b10011;

    // PAGE_READ phase 1 is a single ADDR entry repeated for all five address bytes.
    function automatic phase_kind_e phase_kind(nand_op_e op, logic [2:0] idx);
        phase_kind_e k;
        k = PH_DATA;
        case (op)
            OP_RESET:     k = (idx == 3'd0) ? PH_CMD : PH_RBWAIT;
            OP_READ_ID:   case (idx)
                              3'd0:    k = PH_CMD;
                              3'd1:    k = PH_ADDR;
                              default: k = PH_DATA;
                          endcase
            OP_PAGE_READ: case (idx)
                              3'd0, 3'd2: k = PH_CMD;
                              3'd1:       k = PH_ADDR;
                              3'd3:       k = PH_RBWAIT;
                              default:    k = PH_DATA;
                          endcase
            default:      k = PH_DATA;
        endcase
        return k;
    endfunction

    function automatic logic phase_last(nand_op_e op, logic [2:0] idx);
        case (op)
            OP_RESET:     return idx == 3'd1;
            OP_READ_ID:   return idx == 3'd2;
            OP_PAGE_READ: return idx == 3'd4;
            default:      return 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] phase_opcode(nand_op_e op, logic [2:0] idx);
        case (op)
            OP_RESET:     return CMD_RESET;
            OP_READ_ID:   return CMD_READ_ID;
            OP_PAGE_READ: return (idx == 3'd2) ? CMD_READ2 : CMD_READ1;
            default:      return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/nand_rb_wait.sv
// Ready/busy wait: synchronises R/B#, holds off for tWB after start, then
// pulses rb_ready on a ready flash or rb_timeout if busy lasts too long.
module nand_rb_wait
    import nand_pkg::*;
#(
    parameter int unsigned TWB_CYC    = 20,
    parameter int unsigned RB_TIMEOUT = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic nand_rb_n,
    output logic rb_ready,
    output logic rb_timeout
);

    localparam int unsigned TWB_W = $clog2(TWB_CYC + 2);

    logic [1:0]       rb_sync;
    logic             active;
    logic [TWB_W-1:0] twb_cnt;
    logic [19:0]      to_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rb_sync <= '0;
            active  <= 1'b0;
            twb_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            rb_sync <= {rb_sync[0], nand_rb_n};
            if (start) begin
                active  <= 1'b1;
                twb_cnt <= '0;
                to_cnt  <= '0;
            end else if (active) begin
                if (rb_ready || rb_timeout)
                    active <= 1'b0;
                if (twb_cnt != TWB_W'(TWB_CYC))
                    twb_cnt <= twb_cnt + 1'b1;
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Timeout counts from RBWAIT entry, so the tWB hold-off is part of the budget.
    always_comb begin
        rb_ready   = active && (twb_cnt == TWB_W'(TWB_CYC)) && rb_sync[1];
        rb_timeout = active && !rb_ready && (to_cnt == 20'(RB_TIMEOUT - 1));
    end

endmodule

// File: rtl/nand_cmd_seq.sv
// NAND command sequencer: splits one flash op into CMD/ADDR/RBWAIT/DATA phases
// and drives the toggle engine's enable/done handshake with registered outputs.
module nand_cmd_seq
    import nand_pkg::*;
#(
    parameter int unsigned TWB_CYC    = 20,
    parameter int unsigned RB_TIMEOUT = 500000,
    parameter int unsigned ID_BYTES   = 5,
    parameter int unsigned PAGE_BYTES = 2112
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [39:0] req_addr,
    output logic        cmp_valid,
    output logic        cmp_err,
    input  logic        nand_rb_n,
    output logic [7:0]  dq_out,
    output logic        dq_oe,
    output logic        tg_enable,
    output logic [11:0] tg_cnt,
    output logic [4:0]  tg_vec1,
    output logic [4:0]  tg_vec2,
    input  logic        tg_done
);

    state_e      state, state_n;
    logic [2:0]  phase_idx, phase_n;
    logic [2:0]  addr_idx, addr_n;
    nand_op_e    op_q, op_n;
    logic [39:0] addr_q, addr_qn;
    logic        err_q, err_n;
    logic        phase_end;
    logic        rb_start, rb_ready, rb_timeout;
    phase_kind_e kind_o;
    logic [7:0]  addr_byte;

    logic        req_ready_d, cmp_valid_d, cmp_err_d, tg_enable_d, dq_oe_d;
    logic [11:0] tg_cnt_d;
    logic [4:0]  tg_vec1_d, tg_vec2_d;
    logic [7:0]  dq_out_d;

    assign rb_start = (state_n == ST_RBWAIT) && (state != ST_RBWAIT);

    nand_rb_wait #(
        .TWB_CYC    (TWB_CYC),
        .RB_TIMEOUT (RB_TIMEOUT)
    ) u_rb_wait (
        .clk        (clk),
        .reset      (reset),
        .start      (rb_start),
        .nand_rb_n  (nand_rb_n),
        .rb_ready   (rb_ready),
        .rb_timeout (rb_timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            phase_idx <= '0;
            addr_idx  <= '0;
            op_q      <= OP_RESET;
            addr_q    <= '0;
            err_q     <= 1'b0;
            req_ready <= 1'b1;
            cmp_valid <= 1'b0;
            cmp_err   <= 1'b0;
            tg_enable <= 1'b0;
            tg_cnt    <= 12'd1;
            tg_vec1   <= VEC_IDLE;
            tg_vec2   <= VEC_IDLE;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
        end else begin
            state     <= state_n;
            phase_idx <= phase_n;
            addr_idx  <= addr_n;
            op_q      <= op_n;
            addr_q    <= addr_qn;
            err_q     <= err_n;
            req_ready <= req_ready_d;
            cmp_valid <= cmp_valid_d;
            cmp_err   <= cmp_err_d;
            tg_enable <= tg_enable_d;
            tg_cnt    <= tg_cnt_d;
            tg_vec1   <= tg_vec1_d;
            tg_vec2   <= tg_vec2_d;
            dq_out    <= dq_out_d;
            dq_oe     <= dq_oe_d;
        end
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase_idx;
        addr_n    = addr_idx;
        op_n      = op_q;
        addr_qn   = addr_q;
        err_n     = err_q;
        phase_end = 1'b0;
        unique case (state)
            ST_IDLE: if (req_valid) begin
                op_n    = nand_op_e'(req_op);
                addr_qn = req_addr;
                phase_n = '0;
                addr_n  = '0;
                err_n   = (req_op == OP_RSVD);
                state_n = (req_op == OP_RSVD) ? ST_CMPL : ST_ISSUE;
            end
            ST_ISSUE:   if (tg_done) state_n = ST_RELEASE;
            ST_RELEASE: phase_end = !tg_done;
            ST_RBWAIT: begin
                phase_end = rb_ready;
                if (rb_timeout) begin
                    err_n   = 1'b1;
                    state_n = ST_CMPL;
                end
            end
            ST_CMPL:    state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
        // A PAGE_READ address phase repeats in place until all five bytes are out.
        if (phase_end) begin
            if (phase_kind(op_q, phase_idx) == PH_ADDR && op_q == OP_PAGE_READ &&
                addr_idx != 3'd4) begin
                addr_n  = addr_idx + 3'd1;
                state_n = ST_ISSUE;
            end else if (phase_last(op_q, phase_idx)) begin
                state_n = ST_CMPL;
            end else begin
                phase_n = phase_idx + 3'd1;
                state_n = (phase_kind(op_q, phase_idx + 3'd1) == PH_RBWAIT) ? ST_RBWAIT : ST_ISSUE;
            end
        end
    end

    always_comb begin
        kind_o = phase_kind(op_n, phase_n);
        case (addr_n)
            3'd0:    addr_byte = addr_qn[7:0];
            3'd1:    addr_byte = addr_qn[15:8];
            3'd2:    addr_byte = addr_qn[23:16];
            3'd3:    addr_byte = addr_qn[31:24];
            default: addr_byte = addr_qn[39:32];
        endcase
        if (op_n != OP_PAGE_READ)
            addr_byte = 8'h00;

        req_ready_d = (state_n == ST_IDLE);
        cmp_valid_d = (state_n == ST_CMPL);
        cmp_err_d   = (state_n == ST_CMPL) && err_n;
        tg_enable_d = (state_n == ST_ISSUE);
        tg_cnt_d    = 12'd1;
        tg_vec1_d   = VEC_IDLE;
        tg_vec2_d   = VEC_IDLE;
        dq_out_d    = '0;
        dq_oe_d     = 1'b0;
        if (state_n == ST_ISSUE || state_n == ST_RELEASE) begin
            case (kind_o)
                PH_CMD: begin
                    tg_vec1_d = VEC_CMD_SETUP;
                    tg_vec2_d = VEC_CMD_HOLD;
                    dq_out_d  = phase_opcode(op_n, phase_n);
                    dq_oe_d   = 1'b1;
                end
                PH_ADDR: begin
                    tg_vec1_d = VEC_ADDR_SETUP;
                    tg_vec2_d = VEC_ADDR_HOLD;
                    dq_out_d  = addr_byte;
                    dq_oe_d   = 1'b1;
                end
                PH_DATA: begin
                    tg_vec1_d = VEC_DATA_SETUP;
                    tg_vec2_d = VEC_DATA_HOLD;
                    tg_cnt_d  = (op_n == OP_READ_ID) ? 12'(ID_BYTES) : 12'(PAGE_BYTES);
                end
                default: ;
            endcase
        end
    end

endmodule
